axis_line_splitter: RTL
=======================

// Module: axis_line_splitter
// PURPOSE
//  Demultiplexes one Axis stream (data/sof/eol/valid/ready) into two Axis outputs on line boundaries.
//  Groups of LINE_GROUP lines alternate between m0_axis and m1_axis; every frame restarts on FIRST_DEST.
//  Sits directly upstream of the reorder two-input stream mux, which recombines the paths under its select.
//  Each output is a registered 2-entry skid buffer, so both outputs are timing-isolated from the input.
// PARAMETERS
//  LINE_GROUP   1   consecutive lines sent to one output before toggling; legal range >=1
//  FIRST_DEST   0   output (0 = m0, 1 = m1) that receives the first line of every frame
// PORTS
//  clk_i        in   1    clock; all logic on rising edge
//  rst_i        in   1    reset; asynchronous, active-high
//  s_axis       Axis.Slave   -    input stream; data width from the Axis interface
//  m0_axis      Axis.Master  -    output path 0
//  m1_axis      Axis.Master  -    output path 1
//  dest_o       out  1    destination of the next non-sof input beat (dest_q)
//  sof_err_o    out  1    1-cycle pulse: sof accepted while a line was still open (mid-line)
// BEHAVIOUR
//  Reset (async assert, sync release): m0/m1 valid=0, data/sof/eol=0; s_axis.ready=0 while rst_i=1;
//   dest_q=FIRST_DEST, grp_cnt=0, in_line=0, sof_err_o=0. s_axis.ready=1 from the first edge after release.
//  Accept: input beat accepted when s_axis.valid && s_axis.ready.
//  Routing: beat_dest = s_axis.sof ? FIRST_DEST : dest_q (combinational).
//   s_axis.ready = ready of the beat_dest skid buffer only; the other output never stalls the input.
//  Line/group counting, on each accepted beat:
//   - sof: grp_cnt and dest_q are reset to 0/FIRST_DEST before the eol rule below is applied.
//   - eol: if grp_cnt==LINE_GROUP-1 then grp_cnt<=0 and dest_q<=~beat_dest, else grp_cnt<=grp_cnt+1.
//   - in_line <= ~eol (tracks an open line).
//   - sof && eol (single-beat line) applies both rules in the same cycle.
//  sof_err_o=1 for one cycle after accepting a sof beat while in_line=1. The beat is still routed to
//   FIRST_DEST and the counters restart (sof always wins). No beat is ever dropped.
//  Counter width: $clog2(LINE_GROUP) bits, minimum 1; with LINE_GROUP=1, dest toggles on every eol.
//  Skid buffer (per output):
//   - 2 entries: main register + skid register.
//   - ready_o is registered: ready_o = !skid_valid.
//   - Latency: input accept at cycle N, beat valid on the output at cycle N+1.
//   - Throughput: 1 beat/cycle per output with ready held high.
//   - Output valid, data, sof and eol stay stable until accepted; beats are forwarded unmodified.
//   - Back-pressure: when m ready=0, the buffer holds up to 2 beats, then deasserts its input ready.
//  Ordering: beats within each output keep input order. There is no ordering guarantee between outputs;
//   the consumer must be able to drain either path.
//  Reset mid-operation: all buffered beats are discarded and the counters return to reset values.
//   Any partial line is lost; the next accepted sof restarts cleanly.
// STRUCTURE
//  reorder_pkg:
//   - typedef struct packed {data, sof, eol} axis_beat_t
//   - localparam DEST_M0=1'b0, DEST_M1=1'b1
//  Sub-module axis_skid_buffer:
//   - ports clk_i, rst_i, s_axis, m_axis
//   - instantiated twice, once per output
//  Top-level logic: routing mux, grp_cnt, dest_q, in_line, sof_err_o.
// TESTING
//  LINE_GROUP=1, FIRST_DEST=0; 4 lines x 3 beats, sof on beat 0:
//   -> lines 0 and 2 on m0, lines 1 and 3 on m1, each 3 beats; first output 1 cycle after accept.
//  LINE_GROUP=2; 5 lines, then a new sof:
//   -> lines 0-1 on m0, 2-3 on m1, 4 on m0; the new frame's first line goes to m0 (dest_q reset).
//  Hold m1.ready=0 while streaming lines to m1:
//   -> m1 takes 2 beats, then s_axis.ready=0 until m1.ready=1.
//   -> m0 traffic stays unaffected; no beats are lost or duplicated.
//  Single-beat lines (sof=eol=1 every beat), LINE_GROUP=1:
//   -> every beat is a new frame and goes to m0; dest_o toggles to 1 after each beat; sof_err_o stays 0.
//  sof injected mid-line (after 2 beats of a 4-beat line destined for m1):
//   -> sof_err_o pulses once; the sof beat goes to m0; grp_cnt=0.
//  Assert rst_i for 1 cycle with both buffers full:
//   -> all valid=0 immediately (async); s_axis.ready=1 one edge after release; dest_o=FIRST_DEST.

Source files
------------

// File: rtl/axis_line_splitter_pkg.sv
// Shared types and constants for the line splitter and its skid buffers.
package axis_line_splitter_pkg;

  localparam int DATA_W = 8;

  localparam logic DEST_M0 = 1'b0;
  localparam logic DEST_M1 = 1'b1;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              sof;
    logic              eol;
  } axis_beat_t;

  // Group counter width; a one-line group still needs a 1-bit counter.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axis_line_splitter_if.sv
// Stream bundle carrying data plus start-of-frame / end-of-line markers.
interface axis_line_splitter_if;
  import axis_line_splitter_pkg::*;

  logic [DATA_W-1:0] data;
  logic              sof;
  logic              eol;
  logic              valid;
  logic              ready;

  modport master (output data, output sof, output eol, output valid, input ready);
  modport slave  (input data, input sof, input eol, input valid, output ready);
endinterface

// File: rtl/axis_line_splitter_skid.sv
// Two-entry registered skid buffer: main register feeds the output, skid register
// catches the one beat that arrives while the output is stalled.
module axis_skid_buffer
  import axis_line_splitter_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  axis_line_splitter_if.slave  s_axis,
  axis_line_splitter_if.master m_axis
);

  axis_beat_t r_main;
  axis_beat_t r_skid;
  logic       r_main_vld;
  logic       r_skid_vld;
  logic       r_ready;

  axis_beat_t w_in_beat;
  axis_beat_t w_main_nxt;
  axis_beat_t w_skid_nxt;
  logic       w_main_vld_nxt;
  logic       w_skid_vld_nxt;
  logic       w_in_fire;
  logic       w_out_fire;

  assign w_in_beat  = '{data: s_axis.data, sof: s_axis.sof, eol: s_axis.eol};
  assign w_in_fire  = s_axis.valid && r_ready;
  assign w_out_fire = r_main_vld && m_axis.ready;

  always_comb begin
    w_main_nxt     = r_main;
    w_skid_nxt     = r_skid;
    w_main_vld_nxt = r_main_vld;
    w_skid_vld_nxt = r_skid_vld;
    if (r_skid_vld) begin
      // Input is blocked here; only a drain can move the skid beat forward.
      if (w_out_fire) begin
        w_main_nxt     = r_skid;
        w_skid_vld_nxt = 1'b0;
      end else begin
        w_skid_vld_nxt = 1'b1;
      end
    end else if (w_in_fire) begin
      if (!r_main_vld || w_out_fire) begin
        w_main_nxt     = w_in_beat;
        w_main_vld_nxt = 1'b1;
      end else begin
        w_skid_nxt     = w_in_beat;
        w_skid_vld_nxt = 1'b1;
      end
    end else if (w_out_fire) begin
      w_main_vld_nxt = 1'b0;
    end else begin
      w_main_vld_nxt = r_main_vld;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_main     <= '0;
      r_skid     <= '0;
      r_main_vld <= 1'b0;
      r_skid_vld <= 1'b0;
      r_ready    <= 1'b0;
    end else begin
      r_main     <= w_main_nxt;
      r_skid     <= w_skid_nxt;
      r_main_vld <= w_main_vld_nxt;
      r_skid_vld <= w_skid_vld_nxt;
      r_ready    <= !w_skid_vld_nxt;
    end
  end

  assign s_axis.ready = r_ready;
  assign m_axis.valid = r_main_vld;
  assign m_axis.data  = r_main.data;
  assign m_axis.sof   = r_main.sof;
  assign m_axis.eol   = r_main.eol;

endmodule

// File: rtl/axis_line_splitter.sv
// Routes whole lines of one stream to two outputs, alternating every LINE_GROUP
// lines; each frame (sof) restarts on FIRST_DEST.
module axis_line_splitter
  import axis_line_splitter_pkg::*;
#(
  parameter int   LINE_GROUP = 1,
  parameter logic FIRST_DEST = 1'b0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  axis_line_splitter_if.slave  s_axis,
  axis_line_splitter_if.master m0_axis,
  axis_line_splitter_if.master m1_axis,
  output logic                 dest_o,
  output logic                 sof_err_o
);

  localparam int               CNT_W    = cnt_width(LINE_GROUP);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LINE_GROUP - 1);

  axis_line_splitter_if w_b0 ();
  axis_line_splitter_if w_b1 ();

  logic             r_dest;
  logic             r_in_line;
  logic             r_sof_err;
  logic [CNT_W-1:0] r_grp_cnt;

  logic             w_beat_dest;
  logic             w_accept;
  logic [CNT_W-1:0] w_cnt_base;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_dest_nxt;

  assign w_beat_dest = s_axis.sof ? FIRST_DEST : r_dest;
  assign w_accept    = s_axis.valid && s_axis.ready;

  // Only the selected buffer can stall the input.
  assign s_axis.ready = (w_beat_dest == DEST_M1) ? w_b1.ready : w_b0.ready;

  assign w_b0.valid = s_axis.valid && (w_beat_dest == DEST_M0);
  assign w_b0.data  = s_axis.data;
  assign w_b0.sof   = s_axis.sof;
  assign w_b0.eol   = s_axis.eol;
  assign w_b1.valid = s_axis.valid && (w_beat_dest == DEST_M1);
  assign w_b1.data  = s_axis.data;
  assign w_b1.sof   = s_axis.sof;
  assign w_b1.eol   = s_axis.eol;

  axis_skid_buffer u_skid_m0 (.clk_i(clk_i), .rst_i(rst_i), .s_axis(w_b0), .m_axis(m0_axis));
  axis_skid_buffer u_skid_m1 (.clk_i(clk_i), .rst_i(rst_i), .s_axis(w_b1), .m_axis(m1_axis));

  always_comb begin
    // sof restarts the group before the eol rule so single-beat lines count too.
    w_cnt_base = s_axis.sof ? '0 : r_grp_cnt;
    w_cnt_nxt  = w_cnt_base;
    w_dest_nxt = w_beat_dest;
    if (s_axis.eol) begin
      if (w_cnt_base == CNT_LAST) begin
        w_cnt_nxt  = '0;
        w_dest_nxt = ~w_beat_dest;
      end else begin
        w_cnt_nxt  = w_cnt_base + CNT_W'(1);
        w_dest_nxt = w_beat_dest;
      end
    end else begin
      w_cnt_nxt  = w_cnt_base;
      w_dest_nxt = w_beat_dest;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_dest    <= FIRST_DEST;
      r_grp_cnt <= '0;
      r_in_line <= 1'b0;
      r_sof_err <= 1'b0;
    end else if (w_accept) begin
      r_dest    <= w_dest_nxt;
      r_grp_cnt <= w_cnt_nxt;
      r_in_line <= ~s_axis.eol;
      r_sof_err <= s_axis.sof && r_in_line;
    end else begin
      r_sof_err <= 1'b0;
    end
  end

  assign dest_o    = r_dest;
  assign sof_err_o = r_sof_err;

endmodule
